// File: rtl/uart_bit_streamer.sv
// Packs a 1-bit image memory LSB-first into bytes and feeds them to uart_tx.
// Optional XOR trailer byte: define UART_STREAM_CHKSUM_EN.
module uart_bit_streamer #(
  parameter int NUM_BITS  = 784,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_q,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_rdy,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(NUM_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_HAND,
    S_FLUSH
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [BW-1:0]   bit_idx;
  logic [7:0]      pack;
  logic            ack_pend;
  logic [2:0]      slot;
  logic            last_bit;
  logic            bits_left;
  logic            hand_go;
  logic            chk_more;

`ifdef UART_STREAM_CHKSUM_EN
  logic [7:0]      chk;
  logic            trl_q;
  assign chk_more = !trl_q;
`else
  assign chk_more = 1'b0;
`endif

  assign mem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(bit_idx);
  assign slot      = 3'(bit_idx);
  assign last_bit  = (bit_idx == BW'(NUM_BITS - 1));
  assign bits_left = (bit_idx != BW'(NUM_BITS));
  // uart_tx must have visibly taken the previous byte before reloading
  assign hand_go   = tx_rdy && !ack_pend;

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (start) state_d = S_FETCH;
        end
        (state_q == S_FETCH): begin
          state_d = S_CAPT;
        end
        (state_q == S_CAPT): begin
          if (slot == 3'd7 || last_bit)
            state_d = S_HAND;
          else
            state_d = S_FETCH;
        end
        (state_q == S_HAND): begin
          if (hand_go) begin
            if (bits_left)
              state_d = S_FETCH;
            else if (chk_more)
              state_d = S_HAND;
            else
              state_d = S_FLUSH;
          end
        end
        (state_q == S_FLUSH): begin
          if (hand_go) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bit_idx  <= '0;
      pack     <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      ack_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef UART_STREAM_CHKSUM_EN
      chk      <= '0;
      trl_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (ack_pend && !tx_rdy) ack_pend <= 1'b0;
      if (abort) begin
        busy    <= 1'b0;
        bit_idx <= '0;
        pack    <= '0;
      end else begin
        unique case (1'b1)
          (state_q == S_IDLE): begin
            if (start) begin
              bit_idx <= '0;
              pack    <= '0;
              busy    <= 1'b1;
`ifdef UART_STREAM_CHKSUM_EN
              chk     <= '0;
              trl_q   <= 1'b0;
`endif
            end
          end
          (state_q == S_CAPT): begin
            pack[slot] <= mem_q;
            bit_idx    <= bit_idx + BW'(1);
          end
          (state_q == S_HAND): begin
            if (hand_go) begin
              tx_data  <= pack;
              tx_start <= 1'b1;
              ack_pend <= 1'b1;
              pack     <= '0;
`ifdef UART_STREAM_CHKSUM_EN
              chk      <= chk ^ pack;
              // last data byte: queue the running XOR as the trailer
              if (!bits_left && !trl_q) begin
                pack  <= chk ^ pack;
                trl_q <= 1'b1;
              end
`endif
            end
          end
          (state_q == S_FLUSH): begin
            if (hand_go) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_bit_streamer.sv
// Directed bench for uart_bit_streamer: three instances (784, 12, 16 bits)
// with a registered bit-memory model and a uart_tx model per instance.
module tb_uart_bit_streamer;

  localparam int TX_BUSY = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_s [3];
  logic       abort_s [3];
  logic       mem_q   [3];
  logic       tx_st   [3];
  logic       tx_rdy  [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic       hold    [3];
  logic [9:0] addr    [3];
  logic [7:0] txd     [3];
  logic       mem     [3][1024];
  int         cnt     [3];
  int         ndone   [3];
  int         nlog    [3];
  logic [7:0] log_b   [3][256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_bit_streamer u_a (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
    .mem_addr(addr[0]), .mem_q(mem_q[0]), .tx_data(txd[0]),
    .tx_start(tx_st[0]), .tx_rdy(tx_rdy[0]), .busy(busy_s[0]),
    .done(done_s[0])
  );

  uart_bit_streamer #(.NUM_BITS(12)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
    .mem_addr(addr[1]), .mem_q(mem_q[1]), .tx_data(txd[1]),
    .tx_start(tx_st[1]), .tx_rdy(tx_rdy[1]), .busy(busy_s[1]),
    .done(done_s[1])
  );

  uart_bit_streamer #(.NUM_BITS(16)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]),
    .mem_addr(addr[2]), .mem_q(mem_q[2]), .tx_data(txd[2]),
    .tx_start(tx_st[2]), .tx_rdy(tx_rdy[2]), .busy(busy_s[2]),
    .done(done_s[2])
  );

  always_comb begin
    for (int i = 0; i < 3; i++)
      tx_rdy[i] = (cnt[i] == 0) && !hold[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mem_q[i] <= mem[i][addr[i]];
      if (tx_st[i]) begin
        cnt[i] <= TX_BUSY;
        log_b[i][8'(nlog[i])] <= txd[i];
        nlog[i] <= nlog[i] + 1;
      end else if (cnt[i] != 0) begin
        cnt[i] <= cnt[i] - 1;
      end
      if (done_s[i]) ndone[i] <= ndone[i] + 1;
    end
  end

  task automatic pulse_start(input int ch);
    @(posedge clk); #1 start_s[ch] = 1'b1;
    @(posedge clk); #1 start_s[ch] = 1'b0;
  endtask

  task automatic wait_done(input int ch, input int budget, output bit ok);
    int d0;
    d0 = ndone[ch];
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (ndone[ch] != d0) ok = 1'b1;
    end
  endtask

  task automatic wait_bytes(input int ch, input int n, input int budget,
                            output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (nlog[ch] >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (addr[0] !== 10'd0) begin
      errors++; $display("FAIL reset_addr: got %0h want 0", addr[0]);
    end
    checks++;
    if (txd[0] !== 8'h00) begin
      errors++; $display("FAIL reset_txdata: got %0h want 0", txd[0]);
    end
    checks++;
    if (tx_st[0] !== 1'b0 || busy_s[0] !== 1'b0 || done_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got start=%b busy=%b done=%b want 000",
               tx_st[0], busy_s[0], done_s[0]);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_stream;
    int n0, d0, bad;
    bit ok;
    n0 = nlog[0];
    d0 = ndone[0];
    pulse_start(0);
    checks++;
    if (busy_s[0] !== 1'b1) begin
      errors++; $display("FAIL stream_busy_rise: got %b want 1", busy_s[0]);
    end
    wait_done(0, 98 * 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stream_done_timeout: got none want done");
    end
    repeat (5) @(negedge clk);
    checks++;
    if (nlog[0] - n0 != 98) begin
      errors++; $display("FAIL stream_count: got %0d want 98", nlog[0] - n0);
    end
    bad = 0;
    for (int k = n0; k < nlog[0]; k++)
      if (log_b[0][8'(k)] !== 8'hAA) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stream_data: got %0d bad bytes want 0", bad);
    end
    checks++;
    if (ndone[0] - d0 != 1) begin
      errors++; $display("FAIL stream_done: got %0d pulses want 1", ndone[0] - d0);
    end
    checks++;
    if (busy_s[0] !== 1'b0) begin
      errors++; $display("FAIL stream_busy_end: got %b want 0", busy_s[0]);
    end
  endtask

  task automatic test_partial;
    int n0, d0;
    bit ok;
    n0 = nlog[1];
    d0 = ndone[1];
    pulse_start(1);
    wait_done(1, 400, ok);
    checks++;
    if (!ok || nlog[1] - n0 != 2) begin
      errors++;
      $display("FAIL partial_done_after: got %0d bytes at done want 2",
               nlog[1] - n0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (log_b[1][8'(n0)] !== 8'hFF) begin
      errors++; $display("FAIL partial_b0: got %0h want ff", log_b[1][8'(n0)]);
    end
    checks++;
    if (log_b[1][8'(n0 + 1)] !== 8'h0F) begin
      errors++;
      $display("FAIL partial_b1: got %0h want 0f", log_b[1][8'(n0 + 1)]);
    end
    checks++;
    if (ndone[1] - d0 != 1 || busy_s[1] !== 1'b0) begin
      errors++;
      $display("FAIL partial_end: got done=%0d busy=%b want 1 0",
               ndone[1] - d0, busy_s[1]);
    end
  endtask

  task automatic test_stall;
    int n0;
    bit ok;
    n0 = nlog[1];
    pulse_start(1);
    wait_bytes(1, n0 + 1, 200, ok);
    hold[1] = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (!ok || nlog[1] - n0 != 1) begin
      errors++; $display("FAIL stall_count: got %0d want 1", nlog[1] - n0);
    end
    checks++;
    if (busy_s[1] !== 1'b1) begin
      errors++; $display("FAIL stall_busy: got %b want 1", busy_s[1]);
    end
    hold[1] = 1'b0;
    wait_done(1, 400, ok);
    checks++;
    if (!ok || nlog[1] - n0 != 2) begin
      errors++;
      $display("FAIL stall_resume: got %0d bytes want 2", nlog[1] - n0);
    end
    checks++;
    if (log_b[1][8'(n0 + 1)] !== 8'h0F) begin
      errors++;
      $display("FAIL stall_b1: got %0h want 0f", log_b[1][8'(n0 + 1)]);
    end
  endtask

  task automatic test_back_to_back;
    int n0, d0;
    bit ok;
    n0 = nlog[1];
    d0 = ndone[1];
    pulse_start(1);
    wait_bytes(1, n0 + 1, 200, ok);
    pulse_start(1);
    wait_done(1, 400, ok);
    repeat (40) @(negedge clk);
    checks++;
    if (!ok || nlog[1] - n0 != 2 || ndone[1] - d0 != 1) begin
      errors++;
      $display("FAIL restart_ignored: got bytes=%0d done=%0d want 2 1",
               nlog[1] - n0, ndone[1] - d0);
    end
    checks++;
    if (log_b[1][8'(n0)] !== 8'hFF || log_b[1][8'(n0 + 1)] !== 8'h0F) begin
      errors++;
      $display("FAIL restart_data: got %0h %0h want ff 0f",
               log_b[1][8'(n0)], log_b[1][8'(n0 + 1)]);
    end
  endtask

  task automatic test_abort;
    int n0, d0, bad;
    bit ok;
    n0 = nlog[0];
    d0 = ndone[0];
    pulse_start(0);
    wait_bytes(0, n0 + 5, 400, ok);
    @(posedge clk); #1 abort_s[0] = 1'b1;
    @(posedge clk); #1 abort_s[0] = 1'b0;
    checks++;
    if (!ok || busy_s[0] !== 1'b0 || tx_st[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: got busy=%b start=%b want 0 0",
               busy_s[0], tx_st[0]);
    end
    repeat (400) @(negedge clk);
    checks++;
    if (nlog[0] - n0 != 5 || ndone[0] != d0) begin
      errors++;
      $display("FAIL abort_quiet: got bytes=%0d done=%0d want 5 0",
               nlog[0] - n0, ndone[0] - d0);
    end
    bad = 0;
    for (int k = n0; k < nlog[0]; k++)
      if (log_b[0][8'(k)] !== 8'hAA) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL abort_data: got %0d bad bytes want 0", bad);
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    bit ok;
    n0 = nlog[0];
    pulse_start(0);
    wait_bytes(0, n0 + 1, 200, ok);
    hold[0] = 1'b1;
    repeat (60) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if (addr[0] !== 10'd0 || txd[0] !== 8'h00) begin
      errors++;
      $display("FAIL midrst_data: got addr=%0h data=%0h want 0 0",
               addr[0], txd[0]);
    end
    checks++;
    if (tx_st[0] !== 1'b0 || busy_s[0] !== 1'b0 || done_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: got start=%b busy=%b done=%b want 000",
               tx_st[0], busy_s[0], done_s[0]);
    end
    hold[0] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    n0 = nlog[0];
    pulse_start(0);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (addr[0] !== 10'd1) begin
      errors++; $display("FAIL midrst_addr: got %0h want 1", addr[0]);
    end
    wait_bytes(0, n0 + 1, 200, ok);
    checks++;
    if (!ok || log_b[0][8'(n0)] !== 8'hAA) begin
      errors++;
      $display("FAIL midrst_byte: got %0h want aa", log_b[0][8'(n0)]);
    end
    @(posedge clk); #1 abort_s[0] = 1'b1;
    @(posedge clk); #1 abort_s[0] = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  task automatic test_chksum;
    int n0, want_n;
    bit ok;
    n0 = nlog[2];
`ifdef UART_STREAM_CHKSUM_EN
    want_n = 3;
`else
    want_n = 2;
`endif
    pulse_start(2);
    wait_done(2, 400, ok);
    checks++;
    if (!ok || nlog[2] - n0 != want_n) begin
      errors++;
      $display("FAIL chk_count: got %0d want %0d", nlog[2] - n0, want_n);
    end
    checks++;
    if (log_b[2][8'(n0)] !== 8'h3C || log_b[2][8'(n0 + 1)] !== 8'h0F) begin
      errors++;
      $display("FAIL chk_data: got %0h %0h want 3c 0f",
               log_b[2][8'(n0)], log_b[2][8'(n0 + 1)]);
    end
`ifdef UART_STREAM_CHKSUM_EN
    checks++;
    if (log_b[2][8'(n0 + 2)] !== 8'h33) begin
      errors++;
      $display("FAIL chk_trailer: got %0h want 33", log_b[2][8'(n0 + 2)]);
    end
`endif
  endtask

  initial begin
    logic [15:0] pat;
    pat = 16'h0F3C;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      hold[i]    = 1'b0;
    end
    for (int a = 0; a < 1024; a++) begin
      mem[0][a] = (a % 2) == 1;
      mem[1][a] = 1'b1;
      mem[2][a] = (a < 16) ? pat[a] : 1'b0;
    end
    test_reset;
    test_stream;
    test_partial;
    test_stall;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_chksum;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
